// File: rtl/fifo_pkg.sv
// Shared defaults and payload type for the synchronous FIFO and its stream reader.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 16;
  localparam int unsigned BURST_LEN_DEFAULT  = 4;

  typedef logic [FIFO_WIDTH_DEFAULT-1:0] data_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry ordered buffer that absorbs words arriving one cycle after each FIFO read.
module reader_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       buf_cnt,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head_ptr;
  logic             tail_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      buf_cnt  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO onto a valid/ready stream with a last marker every BURST_LEN beats.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err_underflow,
  output logic [31:0]           beats_sent
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        buf_cnt;
  logic              inflight;
  logic              pop;
  logic [2:0]        committed;
  logic [BEAT_W-1:0] beat_cnt;

  reader_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .head_data (m_data)
  );

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beat_cnt == BEAT_LAST);

  // Credit check: buffered + in-flight words, less the one leaving now, must leave a free slot.
  assign committed  = 3'(buf_cnt) + 3'(inflight);
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (committed < (3'd2 + 3'(pop)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      beats_sent <= 32'd0;
    end else if (pop) begin
      beat_cnt   <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
      beats_sent <= beats_sent + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, ordered-stream reference, directed and random phases.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int W     = 16;
  localparam int BL    = 4;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          err_underflow;
  logic [31:0]   beats_sent;

  fifo_stream_reader #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .err_underflow  (err_underflow),
    .beats_sent     (beats_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: every word ever written lives in load_arr; reads consume it in order.
  data_t load_arr [DEPTH];
  int    load_wr     = 0;
  int    fifo_rd_ptr = 0;
  logic  rd_en_s     = 1'b0;

  assign fifo_empty = (fifo_rd_ptr >= load_wr);

  always @(posedge clk) begin
    if (rd_en_s && fifo_rd_ptr < load_wr) begin
      fifo_data_out <= load_arr[fifo_rd_ptr];
      fifo_rd_ptr   <= fifo_rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stream must be exactly the FIFO read order, with bursts counted from reset.
  int          exp_idx     = 0;
  logic [31:0] model_beats = 32'd0;
  int          burst_pos   = 0;
  logic        model_err   = 1'b0;
  logic        prev_valid  = 1'b0;
  logic        prev_pop    = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic        prev_last   = 1'b0;
  logic [W-1:0] dlog_data [$];
  bit          dlog_last [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_beats", beats_sent, 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        exp_idx     = fifo_rd_ptr;
        model_beats = 32'd0;
        burst_pos   = 0;
        model_err   = 1'b0;
        prev_valid  = 1'b0;
        prev_pop    = 1'b0;
        rd_en_s     = 1'b0;
      end else begin
        chk("beats_sent", beats_sent, model_beats);
        chk("err_underflow", 32'(err_underflow), 32'(model_err));
        chk("occupancy", 32'((fifo_rd_ptr - exp_idx) <= 2), 32'd1);
        if (fifo_rd_en) begin
          chk("rd_while_empty", 32'(fifo_empty), 32'd0);
          chk("rd_while_disabled", 32'(enable), 32'd1);
        end
        if (prev_valid && !prev_pop) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(prev_data));
          chk("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid) begin
          chk("word_available", 32'(exp_idx < fifo_rd_ptr), 32'd1);
          chk("m_data", 32'(m_data), 32'(load_arr[exp_idx % DEPTH]));
          chk("m_last", 32'(m_last), 32'(burst_pos == BL - 1));
        end else begin
          chk("m_last_idle", 32'(m_last), 32'd0);
        end
        prev_valid = m_valid;
        prev_pop   = m_valid && m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
          dlog_data.push_back(m_data);
          dlog_last.push_back(m_last);
          exp_idx++;
          model_beats = model_beats + 32'd1;
          burst_pos   = (burst_pos + 1) % BL;
        end
        if (fifo_underflow) model_err = 1'b1;
        rd_en_s = fifo_rd_en;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input data_t w);
    if (load_wr < DEPTH) begin
      load_arr[load_wr] = w;
      load_wr++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_rd, last_rd, first_val, nrd, base;
    rst_n          = 1'b0;
    enable         = 1'b1;
    m_ready        = 1'b0;
    fifo_underflow = 1'b0;

    // Reset with words waiting in the FIFO.
    for (int i = 0; i < 3; i++) push_word(data_t'(16'hA000 + i));
    repeat (3) step();
    chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t1_valid", 32'(m_valid), 32'd0);
    chk("t1_data", 32'(m_data), 32'd0);
    chk("t1_last", 32'(m_last), 32'd0);
    chk("t1_beats", beats_sent, 32'd0);
    chk("t1_err", 32'(err_underflow), 32'd0);

    // Eight words streamed back to back.
    for (int i = 3; i < 8; i++) push_word(data_t'(16'hA000 + i));
    m_ready = 1'b1;
    rst_n   = 1'b1;
    first_rd = -1; last_rd = -1; first_val = -1; nrd = 0;
    base = dlog_data.size();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = i;
        last_rd = i;
      end
      if (m_valid && first_val < 0) first_val = i;
    end
    step();
    chk("t2_reads", 32'(nrd), 32'd8);
    chk("t2_reads_contiguous", 32'(last_rd - first_rd), 32'd7);
    chk("t2_latency", 32'(first_val - first_rd), 32'd2);
    chk("t2_count", 32'(dlog_data.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < dlog_data.size()) begin
        chk("t2_word", 32'(dlog_data[base + i]), 32'h0000A000 + 32'(i));
        chk("t2_last", 32'(dlog_last[base + i]), 32'(i == 3 || i == 7));
      end
    end
    chk("t2_beats", beats_sent, 32'd8);

    // Sink stalled: only two reads may be outstanding.
    m_ready = 1'b0;
    base = dlog_data.size();
    for (int i = 0; i < 5; i++) push_word(data_t'(16'hB000 + i));
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    chk("t3_reads", 32'(nrd), 32'd2);
    chk("t3_valid", 32'(m_valid), 32'd1);
    chk("t3_head", 32'(m_data), 32'h0000B000);
    step();
    m_ready = 1'b1;
    repeat (12) step();
    chk("t3_count", 32'(dlog_data.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < dlog_data.size())
        chk("t3_word", 32'(dlog_data[base + i]), 32'h0000B000 + 32'(i));
    end

    // Enable dropped for one cycle right after a read.
    base = dlog_data.size();
    for (int i = 0; i < 6; i++) push_word(data_t'(16'hC000 + i));
    @(negedge clk);
    chk("t4_read_before", 32'(fifo_rd_en), 32'd1);
    step();
    enable = 1'b0;
    @(negedge clk);
    chk("t4_no_read", 32'(fifo_rd_en), 32'd0);
    step();
    enable = 1'b1;
    repeat (12) step();
    chk("t4_count", 32'(dlog_data.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < dlog_data.size())
        chk("t4_word", 32'(dlog_data[base + i]), 32'h0000C000 + 32'(i));
    end

    // Sticky underflow flag.
    step();
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    repeat (3) step();
    chk("t5_err", 32'(err_underflow), 32'd1);
    repeat (5) step();
    chk("t5_err_sticky", 32'(err_underflow), 32'd1);

    // Reset with one word buffered and one in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(data_t'(16'hD000 + i));
    step();
    step();
    chk("t6_valid_before", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(m_valid), 32'd0);
    chk("t6_err_cleared", 32'(err_underflow), 32'd0);
    step();
    step();
    base = dlog_data.size();
    m_ready = 1'b1;
    rst_n   = 1'b1;
    repeat (12) step();
    chk("t6_count", 32'(dlog_data.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < dlog_data.size()) begin
        chk("t6_word", 32'(dlog_data[base + i]), 32'h0000D002 + 32'(i));
        chk("t6_last", 32'(dlog_last[base + i]), 32'(i == 3));
      end
    end
    chk("t6_beats", beats_sent, 32'd4);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      enable  = ($urandom % 8) != 0;
      m_ready = ($urandom % 4) != 0;
      if ((load_wr - fifo_rd_ptr) < 6 && ($urandom % 2) == 0)
        push_word(data_t'($urandom));
      step();
    end

    // Drain everything.
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && !(fifo_empty && exp_idx == fifo_rd_ptr && !m_valid); i++) step();
    chk("drain_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("drain_all_delivered", 32'(exp_idx == fifo_rd_ptr), 32'd1);
    chk("drain_idle", 32'(m_valid), 32'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
